sin_req_ctrl: RTL and testbench

- Initiator-side controller for the iterative floating-point `sin` unit.
- Accepts (theta, prec) requests from the voice/wavetable logic over a valid/ready interface and queues them in a small FIFO.
- For each queued request it drives the sin unit's operands, pulses its reset/start, waits for `done` with a watchdog, and returns the result over a valid/ready response port, in order.

---
 rtl/sin_req_ctrl.sv | 140 ++++++++++++++
 tb/tb_sin_req_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sin_req_ctrl.sv
`default_nettype none
// =============================================================================
// Module : sin_req_ctrl
// Queues (theta, prec) requests and sequences them through the iterative sin
// unit with a watchdog, returning results in order.
// Rev    : 1.0
// =============================================================================
module sin_req_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_theta,
  input  logic [31:0]             req_prec,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_data,
  output logic                    resp_timeout,
  output logic                    sin_reset,
  output logic [31:0]             sin_theta,
  output logic [31:0]             sin_prec,
  input  logic [31:0]             sin_result,
  input  logic                    sin_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0]    c_idle     = 2'd0;
  localparam logic [1:0]    c_start    = 2'd1;
  localparam logic [1:0]    c_wait     = 2'd2;
  localparam logic [1:0]    c_out      = 2'd3;
  localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);
  localparam logic [LW-1:0] c_full     = LW'(DEPTH);
  localparam logic [31:0]   c_qnan     = 32'h7FC0_0000;

  logic [31:0]   r_theta_mem [DEPTH];
  logic [31:0]   r_prec_mem  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_theta;
  logic [31:0]   r_prec;
  logic [31:0]   r_resp_data;
  logic          r_resp_timeout;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_done_ok;
  logic w_expire;

  assign w_full    = (r_level == c_full);
  assign w_empty   = (r_level == '0);
  assign w_push    = req_valid && !w_full;
  assign w_pop     = (r_state == c_idle) && !w_empty;
  // A done still high from the previous operation is not trusted on the first WAIT cycle.
  assign w_done_ok = (r_state == c_wait) && sin_done && (r_cnt != '0);
  assign w_expire  = (r_state == c_wait) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_theta_mem[r_wr_ptr] <= req_theta;
      r_prec_mem[r_wr_ptr]  <= req_prec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_state        <= c_idle;
      r_cnt          <= '0;
      r_theta        <= '0;
      r_prec         <= '0;
      r_resp_data    <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      case (r_state)
        c_idle: begin
          if (!w_empty) begin
            r_theta <= r_theta_mem[r_rd_ptr];
            r_prec  <= r_prec_mem[r_rd_ptr];
            r_state <= c_start;
          end
        end
        c_start: begin
          r_cnt   <= '0;
          r_state <= c_wait;
        end
        c_wait: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_done_ok) begin
            r_resp_data    <= sin_result;
            r_resp_timeout <= 1'b0;
            r_state        <= c_out;
          end else if (w_expire) begin
            r_resp_data    <= c_qnan;
            r_resp_timeout <= 1'b1;
            r_state        <= c_out;
          end
        end
        c_out: begin
          if (resp_ready) r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign req_ready    = !w_full;
  assign resp_valid   = (r_state == c_out);
  assign resp_data    = r_resp_data;
  assign resp_timeout = r_resp_timeout;
  assign sin_reset    = (r_state != c_wait);
  assign sin_theta    = r_theta;
  assign sin_prec     = r_prec;
  assign busy         = (r_state != c_idle) || !w_empty;
  assign level        = r_level;

endmodule
`default_nettype wire

// File: tb/tb_sin_req_ctrl.sv
`default_nettype none
// Bench for sin_req_ctrl: behavioural sin unit, in-order response scoreboard,
// a directed vector table, multi-cycle corner sequences and random traffic.
module tb_sin_req_ctrl;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] theta;
    logic [31:0] prec;
    logic [31:0] exp;
  } vec_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_theta = '0;
  logic [31:0]   req_prec  = '0;
  logic [31:0]   req_exp   = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_data;
  logic          resp_timeout;
  logic          sin_reset;
  logic [31:0]   sin_theta;
  logic [31:0]   sin_prec;
  logic [31:0]   sin_result = '0;
  logic          sin_done = 1'b0;
  logic          busy;
  logic [LW-1:0] level;

  logic          t_req_valid = 1'b0;
  logic          t_req_ready;
  logic [31:0]   t_req_theta = '0;
  logic [31:0]   t_req_prec  = '0;
  logic          t_resp_valid;
  logic          t_resp_ready = 1'b0;
  logic [31:0]   t_resp_data;
  logic          t_resp_timeout;
  logic          t_sin_reset;
  logic [31:0]   t_sin_theta;
  logic [31:0]   t_sin_prec;
  logic [31:0]   t_sin_result = '0;
  logic          t_sin_done = 1'b0;
  logic          t_busy;
  logic [LW-1:0] t_level;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_resp = 0;
  logic [31:0] last_data = '0;
  vec_t sbq[$];

  int wcnt = 0;
  int lat = 0;
  bit stale_mode = 1'b0;
  bit rand_lat = 1'b0;

  sin_req_ctrl #(.DEPTH(DEPTH), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_theta(req_theta), .req_prec(req_prec),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_timeout(resp_timeout),
    .sin_reset(sin_reset), .sin_theta(sin_theta), .sin_prec(sin_prec),
    .sin_result(sin_result), .sin_done(sin_done),
    .busy(busy), .level(level)
  );

  sin_req_ctrl #(.DEPTH(DEPTH), .TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset),
    .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_theta(t_req_theta), .req_prec(t_req_prec),
    .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
    .resp_data(t_resp_data), .resp_timeout(t_resp_timeout),
    .sin_reset(t_sin_reset), .sin_theta(t_sin_theta), .sin_prec(t_sin_prec),
    .sin_result(t_sin_result), .sin_done(t_sin_done),
    .busy(t_busy), .level(t_level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sinfn(input logic [31:0] th, input logic [31:0] pr);
    case (th)
      32'h00000000: return 32'h00000000;
      32'h3f800000: return 32'h3f576aa5;
      32'h3f99999a: return 32'h3f6e9a1c;
      32'h3fc90fdb: return 32'h3f800000;
      32'hbf800000: return 32'hbf576aa5;
      32'h40000000: return 32'h3f68c7b7;
      32'h3f000000: return 32'h3ef57744;
      default:      return th ^ {pr[15:0], pr[31:16]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sin_reset"},    32'(sin_reset), 1);
    chk({tag, "_sin_theta"},    sin_theta, 0);
    chk({tag, "_sin_prec"},     sin_prec, 0);
    chk({tag, "_resp_valid"},   32'(resp_valid), 0);
    chk({tag, "_resp_data"},    resp_data, 0);
    chk({tag, "_resp_timeout"}, 32'(resp_timeout), 0);
    chk({tag, "_busy"},         32'(busy), 0);
    chk({tag, "_level"},        32'(level), 0);
    chk({tag, "_req_ready"},    32'(req_ready), 1);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_req(input logic [31:0] th, input logic [31:0] pr, input logic [31:0] ex);
    int g;
    g = 0;
    req_valid = 1'b1;
    req_theta = th;
    req_prec  = pr;
    req_exp   = ex;
    while (!req_ready && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk("push_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_in_time", 32'(g < 3000), 1);
    @(posedge clk); #1;
  endtask

  // Behavioural sin unit: counts cycles since sin_reset fell, asserts done at 'lat'.
  always @(negedge clk) begin
    if (sin_reset) begin
      wcnt = 0;
      if (rand_lat) lat = $urandom_range(1, 12);
    end else begin
      wcnt++;
    end
    if (stale_mode && (sin_reset || wcnt == 1)) begin
      sin_done   = 1'b1;
      sin_result = 32'h12345678;
    end else if (!sin_reset && lat != 0 && wcnt >= lat) begin
      sin_done   = 1'b1;
      sin_result = sinfn(sin_theta, sin_prec);
    end else begin
      sin_done   = 1'b0;
      sin_result = 32'h0;
    end
  end

  // Scoreboard: operands of the head request during WAIT, responses in order.
  always @(negedge clk) begin
    if (reset) begin
      if (!sin_reset) begin
        chk("op_pending", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          chk("op_theta", sin_theta, sbq[0].theta);
          chk("op_prec", sin_prec, sbq[0].prec);
        end
      end
      if (resp_valid && resp_ready) begin
        chk("resp_pending", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          chk("resp_data", resp_data, sbq[0].exp);
          chk("resp_timeout", 32'(resp_timeout), 0);
          last_data = resp_data;
          void'(sbq.pop_front());
          n_resp++;
        end
      end
      if (req_valid && req_ready) sbq.push_back('{req_theta, req_prec, req_exp});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    logic        sr[24];
    logic        rv[24];
    logic [31:0] th[24];
    logic [31:0] pr[24];
    logic [31:0] dd;
    int          nz, n0, g, n, sent;
    bit          acc;

    tbl[0] = '{32'h00000000, 32'h41200000, 32'h00000000};
    tbl[1] = '{32'h3f800000, 32'h41100000, 32'h3f576aa5};
    tbl[2] = '{32'h3f99999a, 32'h40e00000, 32'h3f6e9a1c};
    tbl[3] = '{32'h3fc90fdb, 32'h41000000, 32'h3f800000};
    tbl[4] = '{32'hbf800000, 32'h41100000, 32'hbf576aa5};
    tbl[5] = '{32'h40000000, 32'h41200000, 32'h3f68c7b7};
    tbl[6] = '{32'h3f000000, 32'h40c00000, 32'h3ef57744};

    // Reset state
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    chk("rst_t_sin_reset", 32'(t_sin_reset), 1);
    chk("rst_t_resp_valid", 32'(t_resp_valid), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Single request, done 20 cycles into WAIT
    lat = 20;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_theta = 32'h3f800000; req_prec = 32'h41100000; req_exp = 32'h3f576aa5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    dd = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      sr[i] = sin_reset; rv[i] = resp_valid; th[i] = sin_theta; pr[i] = sin_prec;
      if (i == 22) dd = resp_data;
    end
    nz = 0;
    for (int i = 2; i < 22; i++) if (!sr[i]) nz++;
    chk("t1_idle_sin_reset", 32'(sr[0]), 1);
    chk("t1_start_sin_reset", 32'(sr[1]), 1);
    chk("t1_start_theta", th[1], 32'h3f800000);
    chk("t1_start_prec", pr[1], 32'h41100000);
    chk("t1_wait_cycles", nz, 20);
    chk("t1_valid_before", 32'(rv[21]), 0);
    chk("t1_valid_rise", 32'(rv[22]), 1);
    chk("t1_out_sin_reset", 32'(sr[22]), 1);
    chk("t1_data", dd, 32'h3f576aa5);
    chk("t1_theta_held", th[22], 32'h3f800000);
    drain();

    // Back-to-back table: 3 named vectors plus DEPTH more
    n0 = n_resp;
    for (int i = 0; i < 7; i++) begin
      push_req(tbl[i].theta, tbl[i].prec, tbl[i].exp);
      if (i == DEPTH) begin
        chk("t2_level_full", 32'(level), DEPTH);
        chk("t2_ready_full", 32'(req_ready), 0);
      end
    end
    drain();
    chk("t2_resp_count", n_resp - n0, 7);

    // Consumer stalls during OUT
    lat = 3;
    resp_ready = 1'b0;
    push_req(32'h3f800000, 32'h41100000, 32'h3f576aa5);
    push_req(32'h3f000000, 32'h40c00000, 32'h3ef57744);
    g = 0;
    while (!resp_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("t3_valid_seen", 32'(resp_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_valid_hold", 32'(resp_valid), 1);
      chk("t3_data_hold", resp_data, 32'h3f576aa5);
      chk("t3_sin_reset_hold", 32'(sin_reset), 1);
      chk("t3_no_next_start", sin_theta, 32'h3f800000);
      chk("t3_level_hold", 32'(level), 1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drain();

    // Stale done through START and the first WAIT cycle
    stale_mode = 1'b1;
    lat = 5;
    push_req(32'h3f99999a, 32'h40e00000, 32'h3f6e9a1c);
    drain();
    stale_mode = 1'b0;
    chk("t4_data", last_data, 32'h3f6e9a1c);

    // Watchdog on the TIMEOUT=16 instance
    t_req_valid = 1'b1; t_req_theta = 32'h3f800000; t_req_prec = 32'h41100000;
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    g = 0;
    while (t_sin_reset && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("t5_wait_entered", 32'(t_sin_reset), 0);
    n = 0;
    while (!t_resp_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("t5_latency", n, 16);
    chk("t5_data", t_resp_data, 32'h7FC00000);
    chk("t5_timeout", 32'(t_resp_timeout), 1);
    chk("t5_out_sin_reset", 32'(t_sin_reset), 1);
    @(posedge clk); #1;
    t_resp_ready = 1'b1;
    @(posedge clk); #1;
    t_resp_ready = 1'b0;
    chk("t5_valid_drop", 32'(t_resp_valid), 0);
    chk("t5_idle", 32'(t_busy), 0);

    // Asynchronous reset mid-WAIT with two requests queued
    lat = 20;
    push_req(tbl[1].theta, tbl[1].prec, tbl[1].exp);
    push_req(tbl[2].theta, tbl[2].prec, tbl[2].exp);
    push_req(tbl[3].theta, tbl[3].prec, tbl[3].exp);
    g = 0;
    while (sin_reset && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("t6_in_wait", 32'(sin_reset), 0);
    chk("t6_level_pre", 32'(level), 2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("t6_async");
    sbq.delete();
    @(posedge clk); #1;
    chk("t6_level_held", 32'(level), 0);
    chk("t6_sin_reset_held", 32'(sin_reset), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    lat = 4;
    n0 = n_resp;
    push_req(32'h40000000, 32'h41100000, 32'h3f68c7b7);
    drain();
    chk("t6_after_count", n_resp - n0, 1);
    chk("t6_after_data", last_data, 32'h3f68c7b7);

    // Random traffic against the scoreboard
    rand_lat = 1'b1;
    n0 = n_resp;
    sent = 0;
    g = 0;
    acc = 1'b0;
    while (sent < 40 && g < 4000) begin
      if (!req_valid || acc) begin
        req_valid = ($urandom_range(0, 1) == 1);
        req_theta = $urandom;
        req_prec  = $urandom;
        req_exp   = sinfn(req_theta, req_prec);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      g++;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain();
    rand_lat = 1'b0;
    chk("t7_sent_in_time", 32'(g < 4000), 1);
    chk("t7_resp_count", n_resp - n0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
